// File: rtl/fp_pipe.sv
// fp_pipe: LANES x STAGES lane-permute/filter pipeline with valid/ready
//   backpressure and double-banked configuration rewritable under traffic.
// Optional feature macro: FP_PERF_CNT_EN builds the perf_beats/perf_stalls
//   saturating counters; without it both ports read 0.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_data/in_lane_valid    input lanes (lane L at [L*VEC_W +: VEC_W]) and lane valids
//   in_valid/in_ready        input beat handshake
//   out_data/out_lane_valid  filtered lanes from the last stage
//   out_valid/out_ready      output beat handshake
//   cfg_wr/stage/lane/src/op write one entry of the inactive bank
//   cfg_commit               swap active and inactive banks
//   cfg_ready                cfg_wr and cfg_commit are honoured only when high
//   active_bank              bank tagged onto newly accepted beats
//   perf_beats/perf_stalls   accepted-beat and stall-cycle counters
module fp_pipe #(
  parameter int VEC_W  = 128,
  parameter int LANES  = 8,
  parameter int STAGES = 8,
  parameter int LW     = $clog2(LANES),
  parameter int SW     = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES*VEC_W-1:0] in_data,
  input  logic [LANES-1:0]       in_lane_valid,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [LANES*VEC_W-1:0] out_data,
  output logic [LANES-1:0]       out_lane_valid,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   cfg_wr,
  input  logic [SW-1:0]          cfg_stage,
  input  logic [LW-1:0]          cfg_lane,
  input  logic [LW-1:0]          cfg_src,
  input  logic [2:0]             cfg_op,
  input  logic                   cfg_commit,
  output logic                   cfg_ready,
  output logic                   active_bank,
  output logic [31:0]            perf_beats,
  output logic [31:0]            perf_stalls
);
  typedef logic [LANES-1:0][VEC_W-1:0] vec_t;
  vec_t             dat_q   [STAGES];
  vec_t             dat_d   [STAGES];
  vec_t             sin_dat [STAGES];
  logic [LANES-1:0] lv_q    [STAGES];
  logic [LANES-1:0] lv_d    [STAGES];
  logic [LANES-1:0] sin_lv  [STAGES];
  logic [STAGES-1:0] bv_q, bk_q, sin_bv, sin_bk;
  logic [LW-1:0] src_q [2][STAGES][LANES];
  logic [2:0]    op_q  [2][STAGES][LANES];
  logic active_q, stall, sel, va, vb;
  logic [VEC_W-1:0] a, b;
  logic [2:0] op;
  assign stall = bv_q[STAGES-1] && !out_ready;
  assign in_ready = !stall;
  assign out_valid = bv_q[STAGES-1];
  assign out_data = dat_q[STAGES-1];
  assign out_lane_valid = lv_q[STAGES-1];
  assign active_bank = active_q;
  // A beat tagged with the inactive bank still in flight blocks rewrites of that bank.
  assign cfg_ready = ~|(bv_q & (bk_q ^ {STAGES{active_q}}));
  // Stage inputs: stage 0 sees the incoming beat tagged with the current bank.
  assign sin_dat[0] = in_data;
  assign sin_lv[0] = in_lane_valid;
  assign sin_bv[0] = in_valid;
  assign sin_bk[0] = active_q;
  for (genvar s = 1; s < STAGES; s++) begin : g_chain
    assign sin_dat[s] = dat_q[s-1];
    assign sin_lv[s] = lv_q[s-1];
    assign sin_bv[s] = bv_q[s-1];
    assign sin_bk[s] = bk_q[s-1];
  end
  always_comb begin
    a = '0;
    b = '0;
    va = 1'b0;
    vb = 1'b0;
    sel = 1'b0;
    op = 3'd0;
    for (int s = 0; s < STAGES; s++) begin
      dat_d[s] = '0;
      lv_d[s] = '0;
      sel = sin_bk[s];
      for (int l = 0; l < LANES; l++) begin
        a = sin_dat[s][src_q[sel][s][l]];
        b = sin_dat[s][src_q[sel][s][l ^ 1]];
        va = sin_lv[s][src_q[sel][s][l]];
        vb = sin_lv[s][src_q[sel][s][l ^ 1]];
        op = op_q[sel][s][l];
        dat_d[s][l] = (op == 3'd0) ? a :
                      (op == 3'd1) ? a & b :
                      (op == 3'd2) ? a | b :
                      (op == 3'd3) ? a ^ b :
                      (op == 3'd4) ? a & ~b :
                      (op == 3'd5) ? ~a :
                      (op == 3'd6) ? {VEC_W{1'b0}} : {VEC_W{1'b1}};
        lv_d[s][l] = (op == 3'd2) ? va | vb :
                     (op inside {3'd1, 3'd3, 3'd4}) ? va & vb : va;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bv_q <= '0;
      bk_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        dat_q[s] <= '0;
        lv_q[s] <= '0;
      end
    end else if (!stall) begin
      bv_q <= sin_bv;
      bk_q <= sin_bk;
      for (int s = 0; s < STAGES; s++) begin
        dat_q[s] <= dat_d[s];
        lv_q[s] <= lv_d[s];
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= 1'b0;
      for (int k = 0; k < 2; k++)
        for (int s = 0; s < STAGES; s++)
          for (int l = 0; l < LANES; l++) begin
            src_q[k][s][l] <= LW'(l);
            op_q[k][s][l] <= 3'd0;
          end
    end else if (cfg_ready) begin
      if (cfg_commit) active_q <= !active_q;
      // Writes target the pre-flip inactive bank even when committed in the same cycle.
      if (cfg_wr)
        for (int s = 0; s < STAGES; s++)
          for (int l = 0; l < LANES; l++)
            if (cfg_stage == SW'(s) && cfg_lane == LW'(l)) begin
              src_q[!active_q][s][l] <= cfg_src;
              op_q[!active_q][s][l] <= cfg_op;
            end
    end
  end
`ifdef FP_PERF_CNT_EN
  logic [31:0] beats_q, stalls_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beats_q <= '0;
      stalls_q <= '0;
    end else begin
      if (in_valid && !stall && beats_q != 32'hFFFF_FFFF) beats_q <= beats_q + 32'd1;
      if (stall && stalls_q != 32'hFFFF_FFFF) stalls_q <= stalls_q + 32'd1;
    end
  end
  assign perf_beats = beats_q;
  assign perf_stalls = stalls_q;
`else
  assign perf_beats = '0;
  assign perf_stalls = '0;
`endif
endmodule

// File: tb/tb_fp_pipe.sv
// tb_fp_pipe: directed self-checking bench for fp_pipe (8 lanes, 8 stages, 128-bit lanes).
module tb_fp_pipe;
  localparam int VEC_W = 128;
  localparam int LANES = 8;
  localparam int STAGES = 8;
  localparam int LW = 3;
  localparam int SW = 3;
  typedef logic [LANES-1:0][VEC_W-1:0] vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  vec_t din = '0;
  vec_t dout;
  logic [LANES*VEC_W-1:0] in_data, out_data;
  logic [LANES-1:0] in_lane_valid = '0;
  logic [LANES-1:0] out_lane_valid;
  logic in_valid = 1'b0;
  logic in_ready, out_valid, cfg_ready, active_bank;
  logic out_ready = 1'b1;
  logic cfg_wr = 1'b0;
  logic cfg_commit = 1'b0;
  logic [SW-1:0] cfg_stage = '0;
  logic [LW-1:0] cfg_lane = '0;
  logic [LW-1:0] cfg_src = '0;
  logic [2:0] cfg_op = '0;
  logic [31:0] perf_beats, perf_stalls;
  int n_cmp = 0;
  int n_bad = 0;
  assign in_data = din;
  assign dout = out_data;
  always #5 clk = ~clk;
  fp_pipe #(.VEC_W(VEC_W), .LANES(LANES), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_lane_valid(in_lane_valid), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_lane_valid(out_lane_valid), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_wr(cfg_wr), .cfg_stage(cfg_stage), .cfg_lane(cfg_lane), .cfg_src(cfg_src), .cfg_op(cfg_op),
    .cfg_commit(cfg_commit), .cfg_ready(cfg_ready), .active_bank(active_bank),
    .perf_beats(perf_beats), .perf_stalls(perf_stalls)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t pat(input int base);
    vec_t v;
    for (int l = 0; l < LANES; l++) v[l] = {16{8'(base + l)}};
    return v;
  endfunction
  function automatic vec_t and_in();
    vec_t v = '0;
    v[3] = 128'hF0F0;
    v[5] = 128'hFF00;
    return v;
  endfunction
  function automatic vec_t and_out();
    vec_t v = '0;
    v[0] = 128'hF000;
    v[1] = 128'hF000;
    v[3] = 128'hF0F0;
    v[5] = 128'hFF00;
    return v;
  endfunction
  task automatic cfg_write(input int s, input int l, input int src, input int op);
    cfg_stage = 3'(s);
    cfg_lane = 3'(l);
    cfg_src = 3'(src);
    cfg_op = 3'(op);
    cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
  endtask
  task automatic commit();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_lane_valid !== 8'h00) begin n_bad++; $display("FAIL reset_lane_valid got %h want 00", out_lane_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data got %0d set bits want 0", $countones(out_data)); end
    n_cmp++; if (active_bank !== 1'b0) begin n_bad++; $display("FAIL reset_active_bank got %b want 0", active_bank); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (perf_beats !== 32'd0 || perf_stalls !== 32'd0) begin n_bad++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_beats, perf_stalls); end
  endtask
  task automatic test_identity();
    vec_t e = pat(0);
    din = e;
    in_lane_valid = 8'hFF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ident_early got out_valid %b want 0 at cycle 7", out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ident_latency got out_valid %b want 1 at cycle 8", out_valid); end
    for (int l = 0; l < LANES; l++) begin
      n_cmp++; if (dout[l] !== e[l]) begin n_bad++; $display("FAIL ident_lane%0d got %h want %h", l, dout[l], e[l]); end
    end
    n_cmp++; if (out_lane_valid !== 8'hFF) begin n_bad++; $display("FAIL ident_lane_valid got %h want ff", out_lane_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ident_single got out_valid %b want 0", out_valid); end
  endtask
  task automatic test_back_to_back();
    vec_t e;
    in_lane_valid = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      din = pat(16 * (k + 1));
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    for (int k = 0; k < 3; k++) begin
      step();
      e = pat(16 * (k + 1));
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid beat%0d got %b want 1", k, out_valid); end
      for (int l = 0; l < LANES; l++) begin
        n_cmp++; if (dout[l] !== e[l]) begin n_bad++; $display("FAIL b2b beat%0d lane%0d got %h want %h", k, l, dout[l], e[l]); end
      end
    end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_tail got out_valid %b want 0", out_valid); end
  endtask
  task automatic test_stall();
    vec_t e;
    in_lane_valid = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      din = pat(64 + 16 * k);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_early got out_valid %b want 0", out_valid); end
    step();
    e = pat(64);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== e) begin n_bad++; $display("FAIL stall_first got v=%b lane0 %h want v=1 lane0 %h", out_valid, dout[0], e[0]); end
    out_ready = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
    for (int c = 0; c < 5; c++) begin
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== e || in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_hold cyc%0d got v=%b rdy=%b lane0 %h want v=1 rdy=0 lane0 %h", c, out_valid, in_ready, dout[0], e[0]); end
    end
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step();
      e = pat(64 + 16 * k);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== e) begin n_bad++; $display("FAIL stall_order beat%0d got v=%b lane0 %h want v=1 lane0 %h", k, out_valid, dout[0], e[0]); end
    end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_dup got out_valid %b want 0", out_valid); end
  endtask
  task automatic test_and_cfg();
    vec_t e = and_out();
    cfg_write(0, 0, 3, 1);
    cfg_write(0, 1, 5, 1);
    commit();
    n_cmp++; if (active_bank !== 1'b1) begin n_bad++; $display("FAIL and_commit got bank %b want 1", active_bank); end
    din = and_in();
    in_lane_valid = 8'hDF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL and_valid got %b want 1", out_valid); end
    for (int l = 0; l < LANES; l++) begin
      n_cmp++; if (dout[l] !== e[l]) begin n_bad++; $display("FAIL and_lane%0d got %h want %h", l, dout[l], e[l]); end
    end
    n_cmp++; if (out_lane_valid !== 8'hDC) begin n_bad++; $display("FAIL and_lane_valid got %h want dc", out_lane_valid); end
  endtask
  task automatic test_bank_switch();
    vec_t ea = and_in();
    vec_t eb = and_out();
    vec_t ec = pat(8'hA0);
    commit();
    n_cmp++; if (active_bank !== 1'b0) begin n_bad++; $display("FAIL bsw_back_to_0 got %b want 0", active_bank); end
    din = and_in();
    in_lane_valid = 8'hDF;
    in_valid = 1'b1;
    step();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    n_cmp++; if (active_bank !== 1'b1 || cfg_ready !== 1'b0) begin n_bad++; $display("FAIL bsw_commit got bank=%b cfg_ready=%b want 1/0", active_bank, cfg_ready); end
    step();
    in_valid = 1'b0;
    cfg_stage = 3'd0;
    cfg_lane = 3'd2;
    cfg_src = 3'd7;
    cfg_op = 3'd7;
    cfg_wr = 1'b1;
    cfg_commit = 1'b1;
    step();
    cfg_wr = 1'b0;
    cfg_commit = 1'b0;
    n_cmp++; if (active_bank !== 1'b1) begin n_bad++; $display("FAIL bsw_blocked_commit got bank %b want 1", active_bank); end
    repeat (4) step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== ea || out_lane_valid !== 8'hDF) begin n_bad++; $display("FAIL bsw_beatA got v=%b lv=%h lane0 %h want v=1 lv=df lane0 %h", out_valid, out_lane_valid, dout[0], ea[0]); end
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL bsw_ready_A got %b want 0", cfg_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== ea || out_lane_valid !== 8'hDF) begin n_bad++; $display("FAIL bsw_same_cycle got v=%b lv=%h lane0 %h want v=1 lv=df lane0 %h", out_valid, out_lane_valid, dout[0], ea[0]); end
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL bsw_ready_A2 got %b want 0", cfg_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== eb || out_lane_valid !== 8'hDC) begin n_bad++; $display("FAIL bsw_beatB got v=%b lv=%h lane0 %h want v=1 lv=dc lane0 %h", out_valid, out_lane_valid, dout[0], eb[0]); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL bsw_ready_B got %b want 1", cfg_ready); end
    step();
    commit();
    din = ec;
    in_lane_valid = 8'hFF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    n_cmp++; if (out_valid !== 1'b1 || dout[2] !== ec[2]) begin n_bad++; $display("FAIL bsw_ignored_wr got v=%b lane2 %h want v=1 lane2 %h", out_valid, dout[2], ec[2]); end
  endtask
  task automatic test_midstream_reset();
    vec_t e = and_in();
    logic seen = 1'b0;
    commit();
    n_cmp++; if (active_bank !== 1'b1) begin n_bad++; $display("FAIL mrst_pre_bank got %b want 1", active_bank); end
    in_lane_valid = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      din = pat(8'hC0 + 8 * k);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mrst_pre_valid got %b want 1", out_valid); end
    rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_lane_valid !== 8'h00 || out_data !== '0) begin n_bad++; $display("FAIL mrst_async_out got v=%b lv=%h lane0 %h want 0/00/0", out_valid, out_lane_valid, dout[0]); end
    n_cmp++; if (active_bank !== 1'b0 || cfg_ready !== 1'b1) begin n_bad++; $display("FAIL mrst_async_cfg got bank=%b cfg_ready=%b want 0/1", active_bank, cfg_ready); end
    step();
    step();
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      seen = seen | out_valid;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mrst_dropped got out_valid seen %b want 0", seen); end
    commit();
    n_cmp++; if (active_bank !== 1'b1) begin n_bad++; $display("FAIL mrst_commit got %b want 1", active_bank); end
    din = e;
    in_lane_valid = 8'hDF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    n_cmp++; if (out_valid !== 1'b1 || out_lane_valid !== 8'hDF) begin n_bad++; $display("FAIL mrst_ident_valid got v=%b lv=%h want 1/df", out_valid, out_lane_valid); end
    for (int l = 0; l < LANES; l++) begin
      n_cmp++; if (dout[l] !== e[l]) begin n_bad++; $display("FAIL mrst_ident_lane%0d got %h want %h", l, dout[l], e[l]); end
    end
  endtask
  task automatic test_perf();
`ifdef FP_PERF_CNT_EN
    logic [31:0] exp_beats = 32'd10;
    logic [31:0] exp_stalls = 32'd3;
`else
    logic [31:0] exp_beats = 32'd0;
    logic [31:0] exp_stalls = 32'd0;
`endif
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    in_lane_valid = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      din = pat(k);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    repeat (10) step();
    n_cmp++; if (perf_beats !== exp_beats) begin n_bad++; $display("FAIL perf_beats got %0d want %0d", perf_beats, exp_beats); end
    n_cmp++; if (perf_stalls !== exp_stalls) begin n_bad++; $display("FAIL perf_stalls got %0d want %0d", perf_stalls, exp_stalls); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL perf_drain got out_valid %b want 0", out_valid); end
  endtask
  initial begin
    test_reset();
    test_identity();
    test_back_to_back();
    test_stall();
    test_and_cfg();
    test_bank_switch();
    test_midstream_reset();
    test_perf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fp_pipe.md
Name: fp_pipe

Overview:
Parametrised successor of the fixed 8x8 filter pipeline. It moves LANES bit-vector lanes through STAGES registered stages. Each stage holds a lane permutation (a full crossbar select, which replaces the Benes network) and a per-lane bitwise filter op.
- Adds a valid/ready handshake with backpressure and per-lane valid propagation.
- Adds double-banked configuration, so the config can be rewritten while traffic runs; every beat carries the config bank that was active when it was accepted.

Parameters:
VEC_W, 128, width of one lane bit vector
LANES, 8, number of lanes; power of two, >=2
STAGES, 8, number of pipeline stages, >=1
LW, $clog2(LANES), lane index width (derived)
SW, $clog2(STAGES) (min 1), stage index width (derived)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
in_data  in  LANES*VEC_W  lane L at bits [L*VEC_W +: VEC_W]
in_lane_valid  in  LANES  per-lane valid
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
out_data  out  LANES*VEC_W  filtered lanes
out_lane_valid  out  LANES  per-lane valid
out_valid  out  1  output beat valid
out_ready  in  1  downstream accept
cfg_wr  in  1  write one lane entry into the inactive bank
cfg_stage  in  SW  target stage
cfg_lane  in  LW  target output lane
cfg_src  in  LW  source lane for that output lane
cfg_op  in  3  filter opcode
cfg_commit  in  1  swap the active and inactive banks
cfg_ready  out  1  cfg_wr and cfg_commit are honoured only when high
active_bank  out  1  current active bank
perf_beats  out  32  accepted-beat count (FP_PERF_CNT_EN only)
perf_stalls  out  32  stall-cycle count (FP_PERF_CNT_EN only)

Behaviour:
- Reset (rst=0, asynchronous):
  - Every stage valid bit, out_valid, out_data and out_lane_valid go to 0.
  - active_bank goes to 0.
  - Both banks go to identity: src=lane, op=PASS.
  - Perf counters go to 0.
  - A reset mid-stream drops all in-flight beats. No output appears until new input arrives.
- Pipeline:
  - Stage s has registers data[s], lvalid[s], bvalid[s] and bank[s].
  - stall = out_valid && !out_ready. When stalled, every stage holds its contents.
  - in_ready = !stall, registered-free.
  - Latency is exactly STAGES cycles from acceptance to out_valid when there is no stall. Throughput is 1 beat per cycle.
  - Bubbles advance like beats, so a stage may hold bvalid=0.
- Stage s compute, using the config of the bank tagged on the beat entering the stage. For each output lane L:
  - a = in[src[L]]; b = in[src[L^1]]; va and vb are the matching lane valids.
  - op 0 PASS: out=a, valid=va.
  - op 1 AND: out=a&b, valid=va&vb.
  - op 2 OR: out=a|b, valid=va|vb.
  - op 3 XOR: out=a^b, valid=va&vb.
  - op 4 ANDN: out=a&~b, valid=va&vb.
  - op 5 NOT: out=~a, valid=va.
  - op 6 ZERO: out=0, valid=va.
  - op 7 ONES: out=all 1, valid=va.
- Stage 0 takes its input from in_data. Stage s>0 takes it from stage s-1. Outputs come from stage STAGES-1.
- Banks:
  - bank[0] captures active_bank at acceptance.
  - cfg_wr writes the inactive bank at (cfg_stage, cfg_lane).
  - cfg_commit toggles active_bank at the clock edge. A beat accepted in the same cycle as a commit uses the old bank.
  - When cfg_wr and cfg_commit occur in the same cycle, the write lands in the pre-flip inactive bank, which then becomes active.
- cfg_ready = no stage holding bvalid=1 with bank == inactive bank.
  - This guarantees that in-flight beats never see their config change.
  - cfg_wr or cfg_commit asserted while cfg_ready=0 is ignored (no state change).
  - A cfg_stage value >= STAGES is ignored.

Optional Feature:
FP_PERF_CNT_EN:
- When defined: perf_beats increments on each accepted beat, and perf_stalls increments on each cycle with stall=1. Both are 32-bit, saturate at 0xFFFFFFFF, and reset to 0.
- When undefined: both ports are tied to 0 and no counter logic is built.

Test Plan:
- Identity config, STAGES=8, LANES=8, lane L = L replicated, all lane valids = 1, out_ready=1 -> after exactly 8 cycles out_data equals in_data and out_lane_valid=0xFF; back-to-back beats emerge one per cycle.
- Stage 0 bank1 configured with lane0 src=3, lane1 src=5, op AND, then commit; input lane3=0xF0F0, lane5=0xFF00, lane5 valid=0 -> out lane0=0xF000 with valid 0; out lane1=0xF000 with valid 0.
- Stream 4 beats, hold out_ready=0 for 5 cycles after the first output -> in_ready=0 during the stall; no beat lost or duplicated; order preserved.
- Accept beat A on bank0, commit while A is in flight, accept beat B -> A uses bank0 and B uses bank1; cfg_ready=0 until A exits; a cfg_wr attempted while cfg_ready=0 leaves the config unchanged.
- Assert rst=0 mid-stream with 5 beats in flight -> out_valid=0 immediately; active_bank=0; identity config restored.
- With FP_PERF_CNT_EN: 10 beats accepted and 3 stall cycles -> perf_beats=10, perf_stalls=3.
